// File: rtl/demux_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake and per-lane holding registers.
// Define DEMUX_AUTO_SEL_EN to fill lanes round-robin from an internal pointer instead of select.
module demux_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_take,
    output logic [7:0]       xfer_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t      lane_state [4];
    lane_state_t      lane_next  [4];
    logic [WIDTH-1:0] lane_data  [4];
    logic [1:0]       target;
    logic             accept;
    logic [3:0]       wr_en;

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0] ptr;

    // Pointer only moves on an accept, so a stalled lane holds the rotation in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (accept) begin
            ptr <= ptr + 2'd1;
        end
    end

    assign target = ptr;
`else
    assign target = select;
`endif

    // A full lane being taken this cycle frees its slot in time for the incoming word.
    assign in_ready = ~out_valid[target] | out_take[target];
    assign accept   = in_valid & in_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_en = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            lane_next[i] = lane_state[i];
            wr_en[i]     = accept && (target == 2'(i));
            case (lane_state[i])
                EMPTY: if (wr_en[i]) lane_next[i] = FULL;
                FULL:  if (!wr_en[i] && out_take[i]) lane_next[i] = EMPTY;
                default: lane_next[i] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                lane_state[i] <= EMPTY;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                lane_state[i] <= lane_next[i];
            end
        end
    end

    // NOTE: the holding registers are reset as well, because downstream logic reads them as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                lane_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_en[i]) begin
                    lane_data[i] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= 8'd0;
        end else if (accept) begin
            xfer_count <= xfer_count + 8'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_valid[i] = (lane_state[i] == FULL);
        end
    end

    assign out_a = lane_data[0];
    assign out_b = lane_data[1];
    assign out_c = lane_data[2];
    assign out_d = lane_data[3];

endmodule

// File: tb/tb_demux_reg.sv
// Directed self-checking bench for demux_reg; expected values are hand-derived constants.
// Define DEMUX_AUTO_SEL_EN for both bench and RTL to exercise the round-robin build.
module tb_demux_reg;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       select;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_d;
    logic [3:0]       out_valid;
    logic [3:0]       out_take;
    logic [7:0]       xfer_count;

    int checks   = 0;
    int failures = 0;

    demux_reg #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .select     (select),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_d      (out_d),
        .out_valid  (out_valid),
        .out_take   (out_take),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle inputs/outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        select   = 2'b00;
        out_take = 4'b0000;
        #12;
        rst_n = 1'b1;
        step();

        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_count", 32'(xfer_count), 32'h0);
        check("reset_ready", 32'(in_ready), 32'h1);

`ifndef DEMUX_AUTO_SEL_EN
        // Routing: one word per lane on consecutive cycles.
        in_valid = 1'b1;
        select = 2'b00; in_data = 16'hFFFF; step();
        select = 2'b01; in_data = 16'hDFFF; step();
        select = 2'b10; in_data = 16'hBFFF; step();
        select = 2'b11; in_data = 16'h9FFF; step();
        in_valid = 1'b0;
        check("route_a", 32'(out_a), 32'hFFFF);
        check("route_b", 32'(out_b), 32'hDFFF);
        check("route_c", 32'(out_c), 32'hBFFF);
        check("route_d", 32'(out_d), 32'h9FFF);
        check("route_valid", 32'(out_valid), 32'hF);
        check("route_count", 32'(xfer_count), 32'd4);

        // Backpressure on full lane b, then release by a same-cycle take.
        in_valid = 1'b1; select = 2'b01; in_data = 16'h1234; out_take = 4'b0000;
        #1;
        check("bp_ready_low", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_b", 32'(out_b), 32'hDFFF);
            check("bp_ready_stall", 32'(in_ready), 32'h0);
        end
        check("bp_count_hold", 32'(xfer_count), 32'd4);
        out_take = 4'b0010;
        #1;
        check("bp_ready_take", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0; out_take = 4'b0000;
        check("bp_new_b", 32'(out_b), 32'h1234);
        check("bp_valid", 32'(out_valid), 32'hF);
        check("bp_count", 32'(xfer_count), 32'd5);

        // Take only: c empties, value retained; then a taken twice.
        out_take = 4'b0100; step();
        check("take_c_valid", 32'(out_valid), 32'hB);
        check("take_c_data", 32'(out_c), 32'hBFFF);
        out_take = 4'b0001; step();
        check("take_a_valid", 32'(out_valid), 32'hA);
        out_take = 4'b0001; step();
        check("take_empty_a", 32'(out_valid), 32'hA);
        check("take_empty_a_data", 32'(out_a), 32'hFFFF);
        check("take_count", 32'(xfer_count), 32'd5);

        // Accept into full d while taking d and b in the same cycle.
        in_valid = 1'b1; select = 2'b11; in_data = 16'h5A5A; out_take = 4'b1010;
        step();
        in_valid = 1'b0; out_take = 4'b0000;
        check("mix_d", 32'(out_d), 32'h5A5A);
        check("mix_valid", 32'(out_valid), 32'h8);
        check("mix_count", 32'(xfer_count), 32'd6);

        // Refill all lanes, then reset mid-stream with a transfer pending.
        in_valid = 1'b1;
        select = 2'b00; in_data = 16'h0A0A; step();
        select = 2'b01; in_data = 16'h0B0B; step();
        select = 2'b10; in_data = 16'h0C0C; step();
        select = 2'b11; in_data = 16'h0D0D; out_take = 4'b1000; step();
        out_take = 4'b0000;
        check("full_valid", 32'(out_valid), 32'hF);
        check("full_count", 32'(xfer_count), 32'd10);
        rst_n = 1'b0;
        #1;
        check("async_rst_a", 32'(out_a), 32'h0);
        check("async_rst_b", 32'(out_b), 32'h0);
        check("async_rst_c", 32'(out_c), 32'h0);
        check("async_rst_d", 32'(out_d), 32'h0);
        check("async_rst_valid", 32'(out_valid), 32'h0);
        check("async_rst_count", 32'(xfer_count), 32'h0);
        check("async_rst_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        #1;

        // Counter wrap: 256 accepts into d with d taken every cycle.
        in_valid = 1'b1; select = 2'b11; out_take = 4'b1000;
        for (int i = 0; i < 256; i++) begin
            in_data = 16'(i);
            #1;
            check("wrap_ready", 32'(in_ready), 32'h1);
            step();
        end
        in_valid = 1'b0; out_take = 4'b0000;
        check("wrap_count", 32'(xfer_count), 32'h0);
        check("wrap_d", 32'(out_d), 32'h00FF);
        check("wrap_valid", 32'(out_valid), 32'h8);
`else
        // Round-robin fill with select ignored and all lanes drained each cycle.
        in_valid = 1'b1; select = 2'b11; out_take = 4'b1111;
        for (int i = 1; i <= 5; i++) begin
            in_data = 16'(i);
            step();
        end
        in_valid = 1'b0; out_take = 4'b0000;
        check("auto_a", 32'(out_a), 32'd5);
        check("auto_b", 32'(out_b), 32'd2);
        check("auto_c", 32'(out_c), 32'd3);
        check("auto_d", 32'(out_d), 32'd4);
        check("auto_valid", 32'(out_valid), 32'h1);
        check("auto_count", 32'(xfer_count), 32'd5);
        // Next accept must land in b, showing the pointer sits at 1.
        in_valid = 1'b1; select = 2'b00; in_data = 16'h0066;
        step();
        in_valid = 1'b0;
        check("auto_ptr_b", 32'(out_b), 32'h0066);
        check("auto_ptr_valid", 32'(out_valid), 32'h3);
        // Pointer now at c; fill c and d, then a is full so the producer stalls.
        in_valid = 1'b1;
        in_data = 16'h0077; step();
        in_data = 16'h0088; step();
        in_data = 16'h0099;
        #1;
        check("auto_stall_ready", 32'(in_ready), 32'h0);
        step();
        check("auto_stall_a", 32'(out_a), 32'd5);
        check("auto_stall_count", 32'(xfer_count), 32'd8);
        in_valid = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
